regfile_mp: RTL
===============

Name: regfile_mp

Overview:
Parametrised successor to the single-port-write register file used in the single-cycle datapath. It provides:
- two combinational read ports;
- two falling-edge write ports with fixed priority;
- an optional hardwired zero register (XZR) and optional write-to-read bypass;
- a per-register busy scoreboard, so the pipelined datapath can detect operands that have a pending, not-yet-written producer.

Parameters:
DATA_W, 64, register and bus width in bits
ADDR_W, 5, register index width; depth = 2**ADDR_W
ZERO_EN, 1, 1 = register ZERO_REG reads 0 and ignores writes and reservations
ZERO_REG, 31, index of the hardwired zero register (valid only when ZERO_EN=1)
BYPASS, 0, 1 = a same-cycle write is forwarded to the read ports

Ports:
Clk  in  1  clock; register array and scoreboard update on the falling edge
ResetL  in  1  asynchronous active-low reset
RA  in  ADDR_W  read port A index
RB  in  ADDR_W  read port B index
BusA  out  DATA_W  read port A data, combinational
BusB  out  DATA_W  read port B data, combinational
RW0  in  ADDR_W  write port 0 index
BusW0  in  DATA_W  write port 0 data
RegWr0  in  1  write port 0 enable
RW1  in  ADDR_W  write port 1 index
BusW1  in  DATA_W  write port 1 data
RegWr1  in  1  write port 1 enable (higher priority)
RsvReg  in  ADDR_W  register to mark busy
RsvEn  in  1  reservation enable
BusyA  out  1  busy bit of RA
BusyB  out  1  busy bit of RB

Behaviour:
Reset
- ResetL=0 immediately clears every register and every busy bit to 0; no clock edge is needed.
- While ResetL=0: BusA=BusB=0, BusyA=BusyB=0, and all writes and reservations are ignored.
- Deassertion is sampled at the next falling edge of Clk; the first write can land on that edge.

Writes (falling edge of Clk)
- If RegWr0=1, mem[RW0] <= BusW0.
- If RegWr1=1, mem[RW1] <= BusW1.
- If RW0==RW1 and both enables are 1, port 1 wins; the port 0 data is discarded.
- Writes to ZERO_REG are dropped when ZERO_EN=1.

Reads (combinational, zero cycles latency)
- BusA = mem[RA]; BusB = mem[RB].
- When ZERO_EN=1 and the read index equals ZERO_REG, the output is 0.
- With BYPASS=0, a write appears on the read bus only after the falling edge.
- With BYPASS=1, same-cycle write data is forwarded to the read port:
  - if RegWr1=1 and RW1==RA, BusA=BusW1;
  - otherwise, if RegWr0=1 and RW0==RA, BusA=BusW0;
  - otherwise, BusA=mem[RA].
  - BusB follows the same rule with RB.
  - The zero-register override takes precedence over bypass.

Scoreboard (falling edge of Clk)
- A write on either port clears busy[RW].
- RsvEn=1 sets busy[RsvReg].
- If a reservation and a write target the same register on the same edge, the reservation wins and busy ends at 1 (the new producer supersedes the completing one).
- Reserving an already-busy register keeps it at 1.
- busy[ZERO_REG] is always 0 when ZERO_EN=1.
- BusyA=busy[RA], BusyB=busy[RB], both combinational.
- With BYPASS=1, BusyA reads 0 when a same-cycle write to RA is present, unless RsvEn=1 and RsvReg==RA. BusyB follows the same rule with RB.

Other rules
- There is no arithmetic; all indices are unsigned and no wrap-around condition exists.
- Unused index bits do not occur because depth is exactly 2**ADDR_W.

Test Plan:
1. Defaults, reset, fill and readback: hold ResetL=0 and confirm every register reads 0. Release reset, then write register i with value i for i=0..30 using port 0, one falling edge each. Read pairs (1,2) through (29,30) and confirm BusA=i and BusB=i+1. Write 64'h12345678 to register 31 and confirm it still reads 0.
2. Dual-write collision: on one edge, RW0=RW1=5 with BusW0=64'hAAAA and BusW1=64'hBBBB, both enables 1 → register 5 reads 64'hBBBB. In the same edge, RW0=6 and RW1=7 with distinct data → both registers update.
3. Enable low: RegWr0=RegWr1=0 with RW0=3 and BusW0=64'h12345678 → register 3 keeps 3 across the edge.
4. Scoreboard:
   - RsvEn=1, RsvReg=8 → BusyA=1 with RA=8 after the edge.
   - Write register 8 with 64'hC0DE → busy clears and BusA=64'hC0DE.
   - Write and reserve register 9 on the same edge → busy[9] stays 1.
   - Reserve register 31 → BusyA stays 0.
5. Bypass (BYPASS=1 instance): with RA=10, RegWr0=1, RW0=10 and BusW0=64'h55 applied before the falling edge → BusA=64'h55 and BusyA=0 immediately, with no edge needed. With the BYPASS=0 instance, BusA keeps the old value until the edge.
6. Mid-operation reset: reserve several registers and fill them with nonzero data, then pulse ResetL low between clock edges → all registers read 0 and all busy bits read 0 immediately. A write applied while ResetL=0 has no effect.

Source files
------------

// File: rtl/regfile_mp_if.sv
// rtl/regfile_mp_if.sv - read/write/reservation bus of the multi-port register file
interface regfile_mp_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] RA;
  logic [ADDR_W-1:0] RB;
  logic [DATA_W-1:0] BusA;
  logic [DATA_W-1:0] BusB;
  logic [ADDR_W-1:0] RW0;
  logic [DATA_W-1:0] BusW0;
  logic              RegWr0;
  logic [ADDR_W-1:0] RW1;
  logic [DATA_W-1:0] BusW1;
  logic              RegWr1;
  logic [ADDR_W-1:0] RsvReg;
  logic              RsvEn;
  logic              BusyA;
  logic              BusyB;

  modport master (
    output RA, RB, RW0, BusW0, RegWr0, RW1, BusW1, RegWr1, RsvReg, RsvEn,
    input  BusA, BusB, BusyA, BusyB
  );

  modport slave (
    input  RA, RB, RW0, BusW0, RegWr0, RW1, BusW1, RegWr1, RsvReg, RsvEn,
    output BusA, BusB, BusyA, BusyB
  );
endinterface

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - two-read/two-write register file with busy scoreboard
// Array and scoreboard update on the falling edge; reads are combinational.
module regfile_mp #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5,
  parameter int ZERO_EN  = 1,
  parameter int ZERO_REG = 31,
  parameter int BYPASS   = 0
) (
  input logic         Clk,
  input logic         ResetL,
  regfile_mp_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZR = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy;

  logic [DEPTH-1:0]  wr0_hit;
  logic [DEPTH-1:0]  wr1_hit;
  logic [DEPTH-1:0]  rsv_hit;

  function automatic logic is_zero(input logic [ADDR_W-1:0] idx);
    return (ZERO_EN != 0) && (idx == ZR);
  endfunction

  // Decoded per-register write/reserve strobes; the zero register never matches.
  always_comb begin
    wr0_hit = '0;
    wr1_hit = '0;
    rsv_hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!is_zero(ADDR_W'(i))) begin
        wr0_hit[i] = bus.RegWr0 && (bus.RW0 == ADDR_W'(i));
        wr1_hit[i] = bus.RegWr1 && (bus.RW1 == ADDR_W'(i));
        rsv_hit[i] = bus.RsvEn && (bus.RsvReg == ADDR_W'(i));
      end
    end
  end

  always_ff @(negedge Clk or negedge ResetL) begin
    if (!ResetL) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i]  <= '0;
        busy[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr1_hit[i]) begin
          mem[i] <= bus.BusW1;
        end else if (wr0_hit[i]) begin
          mem[i] <= bus.BusW0;
        end
        // A new reservation supersedes a producer completing on the same edge.
        if (rsv_hit[i]) begin
          busy[i] <= 1'b1;
        end else if (wr0_hit[i] || wr1_hit[i]) begin
          busy[i] <= 1'b0;
        end
      end
    end
  end

  logic [ADDR_W-1:0] ridx  [2];
  logic [DATA_W-1:0] rdata [2];
  logic              rbusy [2];

  assign ridx[0] = bus.RA;
  assign ridx[1] = bus.RB;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rdata[p] = mem[ridx[p]];
      rbusy[p] = busy[ridx[p]];
      if (BYPASS != 0) begin
        if (bus.RegWr1 && (bus.RW1 == ridx[p])) begin
          rdata[p] = bus.BusW1;
        end else if (bus.RegWr0 && (bus.RW0 == ridx[p])) begin
          rdata[p] = bus.BusW0;
        end
        if (((bus.RegWr1 && (bus.RW1 == ridx[p])) || (bus.RegWr0 && (bus.RW0 == ridx[p])))
            && !(bus.RsvEn && (bus.RsvReg == ridx[p]))) begin
          rbusy[p] = 1'b0;
        end
      end
      // Reset and the zero register override everything, including bypass.
      if (!ResetL || is_zero(ridx[p])) begin
        rdata[p] = '0;
        rbusy[p] = 1'b0;
      end
    end
  end

  assign bus.BusA  = rdata[0];
  assign bus.BusB  = rdata[1];
  assign bus.BusyA = rbusy[0];
  assign bus.BusyB = rbusy[1];
endmodule
